plic_src_conditioner: RTL
=========================

Name: plic_src_conditioner

Overview:
Front-end stage that sits directly upstream of the PLIC `src` inputs. It takes raw, possibly asynchronous interrupt lines from peripherals and synchronises them into the PLIC clock domain. It also applies a per-source polarity and filters out glitches shorter than a programmable qualification window. Its `src` output connects straight to the PLIC top's `src` port. A sticky per-source glitch flag is exposed so software or a register block can observe rejected pulses.

Parameters:
- SOURCES, 64, number of interrupt lines; must equal the PLIC SOURCES.
- SYNC_STAGES, 2, synchroniser depth; minimum 2.
- FILTER_CYCLES, 4, consecutive stable samples required before `src` changes; 0 = filter bypass.

Ports:
- clk, input, 1, single clock; must be the same clock as the PLIC (PCLK).
- rst, input, 1, reset.
- src_async, input, SOURCES, raw interrupt lines; may be asynchronous.
- pol, input, SOURCES, per-source polarity; 1 = source is active-low; quasi-static.
- src, output, SOURCES, conditioned active-high interrupts to the PLIC.
- glitch, output, SOURCES, sticky flag: a qualification attempt was aborted.
- glitch_clr, input, SOURCES, one-cycle pulse per bit that clears `glitch`.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset (rst=1, sampled on clk):
  - all synchroniser flops = 0
  - all filter states = LOW, counters = 0
  - src = 0, glitch = 0
  - warm-up counter = 0
- Synchroniser: SYNC_STAGES flops per bit, no logic ahead of the first flop. Sample s[i] = sync_out[i] ^ pol[i].
- Warm-up:
  - A global counter counts SYNC_STAGES cycles after rst deasserts.
  - While warm-up is active, filters hold LOW, counters are held at 0, and glitch is not set.
  - This prevents false events from the reset value of the synchroniser while pol=1.
- Per-source filter FSM (F = FILTER_CYCLES ≥ 1), states LOW / RISE / HIGH / FALL:
  - LOW: s=1 -> HIGH if F==1, else RISE with cnt=1. s=0 -> stay.
  - RISE: s=0 -> LOW and set glitch. s=1 with cnt==F-1 -> HIGH. Otherwise cnt++.
  - HIGH: s=0 -> LOW if F==1, else FALL with cnt=1.
  - FALL: s=1 -> HIGH and set glitch. s=0 with cnt==F-1 -> LOW. Otherwise cnt++.
  - src[i] = 1 in HIGH and FALL, 0 in LOW and RISE. src is a registered state decode with no combinational path from inputs.
- Latency from src_async change (meeting setup) to src change is exactly SYNC_STAGES+F cycles.
- Bypass (F=0): src = s taken directly from the last sync flop; latency is SYNC_STAGES; glitch stays 0.
- Counter width is max(1, $clog2(F)). The counter saturates by construction and never wraps.
- Glitch flag:
  - Set takes priority over a simultaneous glitch_clr; the flag stays 1.
  - glitch_clr on a flag that is already 0 has no effect.
- A pol change is treated as an input change and is filtered normally; it may set glitch if it toggles back within F cycles.
- Reset mid-operation: src drops to 0 on the next edge. After release, a source still asserted re-qualifies and src rises at SYNC_STAGES+F cycles after rst release.
- The PLIC edge/level logic downstream sees at most one src transition per F cycles per source.

Decomposition:
- Package plic_src_pkg contains:
  - typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} filter_state_t
  - localparam function for counter width: max(1, $clog2(F))
- Sub-module plic_src_filter: one source's synchroniser, FSM, counter and glitch flag. Parameters SYNC_STAGES and FILTER_CYCLES; it receives the global warm-up flag as an input.
- The top generates SOURCES instances plus the shared warm-up counter.

Test Plan (SYNC_STAGES=2, FILTER_CYCLES=4 unless noted):
1. Clean pulse: after warm-up, src_async[0] 0->1 held 10 cycles, then 0 -> src[0] rises exactly 6 cycles after the rise, falls exactly 6 cycles after the fall; glitch[0]=0.
2. Glitch reject: src_async[3]=1 for 3 cycles -> src[3] stays 0, glitch[3]=1 after cycle 6; glitch_clr[3] pulse -> glitch[3]=0 on the next cycle.
3. Polarity: pol[5]=1 and src_async[5]=1 through reset -> src[5]=0 and glitch[5]=0 throughout warm-up; src_async[5]=0 for 4 cycles -> src[5]=1 after 6 cycles.
4. Glitch set on the same cycle as glitch_clr[3] -> glitch[3]=1 afterwards.
5. Reset mid-operation: src[2]=1, rst=1 for 1 cycle with src_async[2] held at 1 -> src[2]=0 the next cycle, then src[2]=1 exactly 6 cycles after rst release.
6. Bypass (FILTER_CYCLES=0): 1-cycle pulse on src_async[1] -> 1-cycle src[1] pulse 2 cycles later; glitch=0.

Source files
------------

// File: rtl/plic_src_pkg.sv
// Shared types and helpers for the PLIC source conditioner.
// Latency: n/a (package only). Backpressure: n/a.
// Contents: filter_state_t (per-source qualification state), cnt_width().
package plic_src_pkg;

  typedef enum logic [1:0] {LOW, RISE, HIGH, FALL} filter_state_t;

  // The counter only has to reach F-1, so it needs $clog2(F) bits, with a floor of 1.
  function automatic int cnt_width(input int f);
    return (f <= 1) ? 1 : $clog2(f);
  endfunction

endpackage

// File: rtl/plic_src_filter.sv
// One interrupt line: synchroniser, polarity fix-up, glitch-rejecting qualifier, sticky glitch flag.
// Latency: SYNC_STAGES+FILTER_CYCLES cycles from the input edge to src (SYNC_STAGES when bypassed).
// Backpressure: none; this is a free-running level path.
// Ports: clk, rst (sync, active-high), warm (global warm-up active), src_async (raw line),
//        pol (1 = active-low), src (qualified active-high), glitch (sticky), glitch_clr (clear pulse).
module plic_src_filter
  import plic_src_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic warm,
  input  logic src_async,
  input  logic pol,
  output logic src,
  output logic glitch,
  input  logic glitch_clr
);

  // The raw line goes straight into the first flop, with no logic ahead of it.
  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], src_async};
  end

  assign s = sync[SYNC_STAGES-1] ^ pol;

  if (FILTER_CYCLES == 0) begin : g_bypass

    assign src    = s;
    assign glitch = 1'b0;

  end else begin : g_filt

    localparam int            CW       = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    filter_state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          glitch_q, glitch_set;

    always_ff @(posedge clk) begin
      if (rst) begin
        state    <= LOW;
        cnt      <= '0;
        glitch_q <= 1'b0;
      end else begin
        state <= state_d;
        cnt   <= cnt_d;
        // A set wins over a clear arriving on the same cycle.
        if (glitch_set)      glitch_q <= 1'b1;
        else if (glitch_clr) glitch_q <= 1'b0;
      end
    end

    always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      glitch_set = 1'b0;
      if (warm) begin
        // The synchroniser still holds its reset value. With pol=1 that value reads
        // as asserted, so qualification is held off until real samples arrive.
        state_d = LOW;
        cnt_d   = '0;
      end else begin
        unique case (state)
          LOW: if (s) begin
            if (FILTER_CYCLES == 1) state_d = HIGH;
            else begin
              state_d = RISE;
              cnt_d   = CW'(1);
            end
          end
          RISE: begin
            if (!s) begin
              state_d    = LOW;
              cnt_d      = '0;
              glitch_set = 1'b1;
            end else if (cnt == CNT_LAST) begin
              state_d = HIGH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt + CW'(1);
            end
          end
          HIGH: if (!s) begin
            if (FILTER_CYCLES == 1) state_d = LOW;
            else begin
              state_d = FALL;
              cnt_d   = CW'(1);
            end
          end
          FALL: begin
            if (s) begin
              state_d    = HIGH;
              cnt_d      = '0;
              glitch_set = 1'b1;
            end else if (cnt == CNT_LAST) begin
              state_d = LOW;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt + CW'(1);
            end
          end
          default: begin
            state_d = LOW;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Decoded from the state flops only. FALL still counts as asserted because
    // the line has not yet qualified low.
    assign src    = (state == HIGH) || (state == FALL);
    assign glitch = glitch_q;

  end

endmodule

// File: rtl/plic_src_conditioner.sv
// Conditions raw peripheral interrupt lines for the PLIC src port: sync, polarity, deglitch.
// Latency: SYNC_STAGES+FILTER_CYCLES cycles per source (SYNC_STAGES when FILTER_CYCLES=0).
// Backpressure: none.
// Ports: clk, rst (sync, active-high), src_async[SOURCES], pol[SOURCES], src[SOURCES],
//        glitch[SOURCES] (sticky), glitch_clr[SOURCES] (one-cycle clear pulses).
module plic_src_conditioner
  import plic_src_pkg::*;
#(
  parameter int SOURCES       = 64,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SOURCES-1:0] src_async,
  input  logic [SOURCES-1:0] pol,
  output logic [SOURCES-1:0] src,
  output logic [SOURCES-1:0] glitch,
  input  logic [SOURCES-1:0] glitch_clr
);

  // One warm-up counter is shared by all sources. It stays active until every
  // synchroniser stage has been refilled after reset.
  localparam int WW = $clog2(SYNC_STAGES + 1);

  logic [WW-1:0] warm_cnt;
  logic          warm;

  assign warm = (warm_cnt != WW'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (rst)       warm_cnt <= '0;
    else if (warm) warm_cnt <= warm_cnt + WW'(1);
  end

  for (genvar i = 0; i < SOURCES; i++) begin : g_src
    plic_src_filter #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES)
    ) u_filter (
      .clk       (clk),
      .rst       (rst),
      .warm      (warm),
      .src_async (src_async[i]),
      .pol       (pol[i]),
      .src       (src[i]),
      .glitch    (glitch[i]),
      .glitch_clr(glitch_clr[i])
    );
  end

endmodule
